// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed hex display scanner with a double-buffered value (no tearing).
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking of digits 3..1.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYC    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic [3:0]  digit_en,
    output logic [3:0]  nib,
    output logic [3:0]  dig_n,
    output logic        frame_tick
);

    if (REFRESH_DIV < 2 || DEAD_CYC > REFRESH_DIV - 2) begin : gen_bad_params
        $error("seg_scan_ctrl: parameters need 0 <= DEAD_CYC <= REFRESH_DIV-2");
    end

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] TcVal   = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] DeadVal = CntW'(DEAD_CYC);

    typedef enum logic [1:0] {S0, S1, S2, S3} slot_e;

    slot_e           slot_q;
    logic [CntW-1:0] presc_q;
    logic [15:0]     active_q;
    logic [15:0]     shadow_q;
    logic            pending_q;

    logic       tc;
    logic       wrap;
    logic       dead;
    logic       xfer;
    logic       blank;
    logic       show;
    logic [3:0] cur_nib;

    assign tc          = (presc_q == TcVal);
    assign wrap        = tc && (slot_q == S3);
    assign dead        = (presc_q < DeadVal);
    assign value_ready = ~pending_q;
    assign xfer        = value_valid && !pending_q;

    always_comb begin
        cur_nib = 4'h0;
        unique case (slot_q)
            S0: cur_nib = active_q[3:0];
            S1: cur_nib = active_q[7:4];
            S2: cur_nib = active_q[11:8];
            S3: cur_nib = active_q[15:12];
        endcase
    end

`ifdef SEG_SCAN_LZB_EN
    // A digit is blanked only when it and every digit to its left are zero.
    always_comb begin
        blank = 1'b0;
        unique case (slot_q)
            S0: blank = 1'b0;
            S1: blank = (active_q[15:4] == 12'h000);
            S2: blank = (active_q[15:8] == 8'h00);
            S3: blank = (active_q[15:12] == 4'h0);
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign show = !dead && digit_en[slot_q] && !blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            slot_q     <= S0;
            active_q   <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            nib        <= 4'h0;
            dig_n      <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            presc_q    <= tc ? '0 : presc_q + 1'b1;
            if (tc) begin
                slot_q <= slot_e'(slot_q + 2'd1);
            end
            frame_tick <= wrap;
            nib        <= cur_nib;
            dig_n      <= show ? ~(4'b0001 << slot_q) : 4'hF;
            // Copy happens only when pending, so it can never race with a transfer.
            if (xfer) begin
                shadow_q  <= value_in;
                pending_q <= 1'b1;
            end else if (wrap && pending_q) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected per-frame output segments are queued by the
// stimulus and compared by a monitor that run-length encodes {nib, dig_n} after each frame_tick.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    localparam int RefreshDiv = 8;
    localparam int DeadCyc    = 2;
    localparam int FrameCyc   = 4 * RefreshDiv;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic        value_valid;
    logic        value_ready;
    logic [3:0]  digit_en;
    logic [3:0]  nib;
    logic [3:0]  dig_n;
    logic        frame_tick;

    seg_scan_ctrl #(
        .REFRESH_DIV(RefreshDiv),
        .DEAD_CYC   (DeadCyc)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .digit_en   (digit_en),
        .nib        (nib),
        .dig_n      (dig_n),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0] nib;
        logic [3:0] dig;
        logic [7:0] len;
    } seg_t;

    seg_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cap_frames = 0;
    int   cap_left   = 0;
    bit   cap_done   = 1'b0;
    int   done_cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    endtask

    task automatic push_seg(input logic [3:0] n, input logic [3:0] d, input int len);
        seg_t s;
        s.nib = n;
        s.dig = d;
        s.len = 8'(len);
        exp_q.push_back(s);
    endtask

    // One slot: either dark for the whole slot, or DEAD cycles dark then lit.
    task automatic push_slot(input logic [3:0] n, input logic [3:0] d);
        if (d == 4'hF) begin
            push_seg(n, 4'hF, RefreshDiv);
        end else begin
            push_seg(n, 4'hF, DeadCyc);
            push_seg(n, d, RefreshDiv - DeadCyc);
        end
    endtask

    task automatic close_seg(input logic [7:0] val, input int len, input int idx);
        seg_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL seg%0d: got nib/dig/len 0x%0h/%0d, want nothing (queue empty)",
                     idx, val, len);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("seg%0d nib/dig/len", idx), {val, 8'(len)}, {e.nib, e.dig, e.len});
        end
    endtask

    initial begin : monitor
        logic [7:0] run_val;
        int         run_len;
        int         seg_idx;
        run_val = 8'h00;
        run_len = 0;
        seg_idx = 0;
        forever begin
            @(negedge clk);
            if (cap_left != 0) begin
                if (run_len != 0 && {nib, dig_n} == run_val) begin
                    run_len++;
                end else begin
                    if (run_len != 0) begin
                        close_seg(run_val, run_len, seg_idx);
                        seg_idx++;
                    end
                    run_val = {nib, dig_n};
                    run_len = 1;
                end
                cap_left--;
                if (cap_left == 0) begin
                    close_seg(run_val, run_len, seg_idx);
                    seg_idx++;
                    run_len = 0;
                    cap_frames--;
                    if (cap_frames == 0) begin
                        cap_done = 1'b1;
                        done_cyc = cyc;
                    end
                end
            end
            if (cap_left == 0 && cap_frames != 0 && frame_tick === 1'b1) cap_left = FrameCyc;
        end
    end

    task automatic request(input int frames);
        cap_done   = 1'b0;
        cap_frames = frames;
    endtask

    task automatic wait_cap(input string name, input int frames);
        for (int i = 0; i < (frames + 1) * FrameCyc + 8; i++) begin
            @(negedge clk);
            if (cap_done) break;
        end
        check({name, " capture done"}, 32'(cap_done), 32'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  tick_at;
        bit  got;
        rst_n       = 1'b0;
        value_in    = 16'h0000;
        value_valid = 1'b0;
        digit_en    = 4'hF;

        repeat (3) @(negedge clk);
        check("rst dig_n", 32'(dig_n), 32'hF);
        check("rst nib", 32'(nib), 32'h0);
        check("rst frame_tick", 32'(frame_tick), 32'h0);
        check("rst value_ready", 32'(value_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: 0x1234 shown from the frame after the next tick.
        @(negedge clk);
        check("s1 ready before offer", 32'(value_ready), 32'h1);
        value_in    = 16'h1234;
        value_valid = 1'b1;
        push_slot(4'h4, 4'hE);
        push_slot(4'h3, 4'hD);
        push_slot(4'h2, 4'hB);
        push_slot(4'h1, 4'h7);
        request(1);
        @(negedge clk);
        value_valid = 1'b0;
        check("s1 ready after accept", 32'(value_ready), 32'h0);
        wait_cap("s1", 1);

        // Scenario 2: 0xABCD then 0x5678 held until accepted.
        @(negedge clk);
        check("s2 ready before offer", 32'(value_ready), 32'h1);
        value_in    = 16'hABCD;
        value_valid = 1'b1;
        @(negedge clk);
        value_in = 16'h5678;
        check("s2 busy", 32'(value_ready), 32'h0);
        push_slot(4'hD, 4'hE);
        push_slot(4'hC, 4'hD);
        push_slot(4'hB, 4'hB);
        push_slot(4'hA, 4'h7);
        push_slot(4'h8, 4'hE);
        push_slot(4'h7, 4'hD);
        push_slot(4'h6, 4'hB);
        push_slot(4'h5, 4'h7);
        request(2);
        got = 1'b0;
        for (int i = 0; i < FrameCyc + 8; i++) begin
            @(negedge clk);
            if (value_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("s2 ready rises", 32'(got), 32'h1);
        check("s2 ready rises with frame_tick", 32'(frame_tick), 32'h1);
        @(negedge clk);
        value_valid = 1'b0;
        check("s2 second value accepted", 32'(value_ready), 32'h0);
        wait_cap("s2", 2);

        // Scenario 3: only digits 0 and 2 enabled.
        @(negedge clk);
        digit_en    = 4'b0101;
        value_in    = 16'h1234;
        value_valid = 1'b1;
        push_slot(4'h4, 4'hE);
        push_slot(4'h3, 4'hF);
        push_slot(4'h2, 4'hB);
        push_slot(4'h1, 4'hF);
        request(1);
        @(negedge clk);
        value_valid = 1'b0;
        wait_cap("s3", 1);

        // Scenario 4: 0x0070, leading zeros.
        @(negedge clk);
        digit_en    = 4'hF;
        value_in    = 16'h0070;
        value_valid = 1'b1;
        push_slot(4'h0, 4'hE);
        push_slot(4'h7, 4'hD);
`ifdef SEG_SCAN_LZB_EN
        push_seg(4'h0, 4'hF, 2 * RefreshDiv);
`else
        push_slot(4'h0, 4'hB);
        push_slot(4'h0, 4'h7);
`endif
        request(1);
        @(negedge clk);
        value_valid = 1'b0;
        wait_cap("s4", 1);

        // Scenario 5: pending 0x9999 discarded by a reset in slot 2.
        @(negedge clk);
        value_in    = 16'h9999;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        check("s5 pending", 32'(value_ready), 32'h0);
        while (cyc < done_cyc + 20) @(negedge clk);
`ifdef SEG_SCAN_LZB_EN
        check("s5 dig_n in slot 2 before reset", 32'(dig_n), 32'hF);
`else
        check("s5 dig_n in slot 2 before reset", 32'(dig_n), 32'hB);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("s5 async dig_n", 32'(dig_n), 32'hF);
        check("s5 async nib", 32'(nib), 32'h0);
        check("s5 async value_ready", 32'(value_ready), 32'h1);
        check("s5 async frame_tick", 32'(frame_tick), 32'h0);
        push_slot(4'h0, 4'hE);
`ifdef SEG_SCAN_LZB_EN
        push_seg(4'h0, 4'hF, 3 * RefreshDiv);
`else
        push_slot(4'h0, 4'hD);
        push_slot(4'h0, 4'hB);
        push_slot(4'h0, 4'h7);
`endif
        request(1);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        tick_at = 0;
        for (int k = 1; k <= FrameCyc + 8; k++) begin
            @(negedge clk);
            if (k == 1) check("s5 resume dead dig_n", 32'(dig_n), 32'hF);
            if (k == 3) check("s5 resume on dig_n", 32'(dig_n), 32'hE);
            if (frame_tick) begin
                tick_at = k;
                break;
            end
        end
        check("s5 first tick cycle", 32'(tick_at), 32'(FrameCyc));
        check("s5 ready after reset", 32'(value_ready), 32'h1);
        wait_cap("s5", 1);

        check("expected queue drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
